mprj_io_serial_loader: RTL
==========================

Name: mprj_io_serial_loader

Overview:
- Drives the serial configuration chain that programs the per-pad GPIO control blocks.
- Those control blocks generate the pad-facing mprj_io_oe/ie/pullup_sel/pulldown_sel/schmitt_sel/slew_sel/drive_sel bundle consumed by the padframe.
- Fetches one configuration word per pad from a management-side register array and shifts all words MSB-first into the chain.
- Then pulses a load strobe so that every control block applies its new configuration at the same time.

Parameters:
NUM_PADS, `MPRJ_IO_PADS (38), number of pads (control blocks) in the chain
CFG_BITS, 13, configuration bits per pad
CLK_DIV, 2, serial clock half-period in clock cycles; legal range >=1
IDXW, $clog2(NUM_PADS), width of cfg_index (derived, not overridden)

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to (re)load the whole chain
cfg_word  input  CFG_BITS  configuration word for pad cfg_index; sampled at capture edges only
cfg_index  output  IDXW  pad whose word is requested
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the load strobe completes
serial_clock  output  1  chain shift clock
serial_data  output  1  chain serial data
serial_load  output  1  chain apply strobe
serial_resetn  output  1  active-low chain reset

Behaviour:
Interface rules:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: cfg_index=NUM_PADS-1, busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, serial_resetn=0.
- serial_resetn rises on the first edge with reset low and stays 1 until the next reset.

States: IDLE, SHIFT, LOAD.

IDLE:
- On an edge with start=1 (call it E0), the block does the following on that edge:
  - captures cfg_word into a CFG_BITS shift register;
  - sets serial_data = cfg_word[CFG_BITS-1];
  - sets busy=1;
  - decrements cfg_index;
  - enters SHIFT.

SHIFT:
- Bit period is T = 2*CLK_DIV cycles.
- serial_data changes only on the edge where serial_clock goes (or stays) low.
- serial_clock is low for the first CLK_DIV cycles of each bit and high for the last CLK_DIV cycles. This gives CLK_DIV cycles of setup and CLK_DIV cycles of hold around each rising edge.
- Bits go MSB first within a word.
- Words go from pad NUM_PADS-1 down to pad 0, so the first word sent ends up furthest down the chain.
- Word capture:
  - At the end of the last bit of each word (edge E0 + k*CFG_BITS*T), the next cfg_word is captured and cfg_index decrements.
  - cfg_index is therefore stable for a full word time before each capture.
  - After the final capture (pad 0), cfg_index holds 0 until done.
- Total bits B = NUM_PADS*CFG_BITS.
- At edge E0 + B*T: serial_clock=0, serial_data=0, serial_load=1, enter LOAD.

LOAD:
- serial_load stays high for CLK_DIV cycles.
- At edge E0 + B*T + CLK_DIV: serial_load=0, busy=0, done=1, cfg_index=NUM_PADS-1, enter IDLE.
- done is high for exactly one cycle, which is the first IDLE cycle.

Start handling:
- start while busy=1 is ignored. It is not queued.
- start in the done cycle is accepted; that edge is the new E0.

Reset mid-transfer:
- Aborts immediately; all outputs return to their reset values.
- serial_resetn=0 clears the partially shifted chain.
- No done pulse is produced.

Timing:
- Latency from E0 to the done pulse is B*T + CLK_DIV cycles.
- Default parameters: 38*13*4 + 2 = 1978 cycles.

Test Plan:
- NUM_PADS=2, CFG_BITS=4, CLK_DIV=1; cfg_word=0xA when cfg_index=1 and 0x5 when cfg_index=0; pulse start.
  - serial_data sampled at the 8 serial_clock rising edges = 1,0,1,0,0,1,0,1.
  - serial_load high exactly 1 cycle at E0+16.
  - done at E0+17; busy high for cycles E0..E0+16.
- Default parameters, random cfg_word per index.
  - Scoreboard shift-register model of 38 x 13 reconstructs every word.
  - Exactly 494 serial_clock rising edges; done 1978 cycles after E0.
- CLK_DIV=3: serial_clock high 3 cycles and low 3 cycles per bit.
  - serial_data never changes while serial_clock=1 or in the cycle it rises.
  - cfg_word changed off-capture-edge has no effect on the transmitted data.
- start pulsed at E0+5 and E0+40 during a transfer.
  - Both ignored; total rising-edge count unchanged; single done pulse.
- reset asserted at E0+100 for 2 cycles.
  - Next cycle after assertion: serial_resetn=0, busy=0, serial_clock=0, serial_load=0, cfg_index=NUM_PADS-1; no done.
  - serial_resetn=1 on the first edge after release; a new start then completes normally.
- start held high through the done cycle.
  - New transfer begins on the done edge; busy low for exactly that one cycle; second transfer bit-identical to the first.

Source files
------------

// File: rtl/mprj_io_serial_loader.sv
// -----------------------------------------------------------------------------
// mprj_io_serial_loader
//
// Programs the per-pad GPIO control blocks through their serial configuration
// chain. On start, one configuration word per pad is fetched from the
// management-side register array (pad NUM_PADS-1 first, pad 0 last). Each word
// is shifted MSB-first into the chain. A final load strobe then makes every
// control block apply its new configuration at the same time.
//
// Ports:
//   clock          core clock
//   reset          synchronous, active-high reset
//   start          single-cycle request to (re)load the whole chain
//   cfg_word       configuration word for pad cfg_index (sampled at captures)
//   cfg_index      pad whose word is requested
//   busy           transfer in progress
//   done           one-cycle pulse when the load strobe completes
//   serial_clock   chain shift clock (low first half, high second half of bit)
//   serial_data    chain serial data, changes only while serial_clock is low
//   serial_load    chain apply strobe, high for CLK_DIV cycles
//   serial_resetn  active-low chain reset, released on first edge out of reset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module mprj_io_serial_loader #(
    parameter int NUM_PADS = `MPRJ_IO_PADS,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    parameter int IDXW     = $clog2(NUM_PADS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CFG_BITS-1:0] cfg_word,
    output logic [IDXW-1:0]     cfg_index,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int DIVW = $clog2(2 * CLK_DIV) + 1;
    localparam int BITW = $clog2(CFG_BITS) + 1;

    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [DIVW-1:0] DIV_RISE = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_ONE  = BITW'(1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(CFG_BITS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NUM_PADS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    state_e              state_q;
    logic [DIVW-1:0]     div_q;    // cycle within the current bit (or load strobe)
    logic [BITW-1:0]     bit_q;    // bit within the current word
    logic [IDXW-1:0]     word_q;   // words still to fetch after the current one
    // The word's MSB lives in serial_data; only the remaining bits are held here.
    logic [CFG_BITS-2:0] shreg_q;

    // NOTE: every register in this block is updated with non-blocking
    // assignments so all of them see the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            word_q        <= '0;
            shreg_q       <= '0;
            cfg_index     <= IDX_TOP;
            busy          <= 1'b0;
            done          <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
        end else begin
            serial_resetn <= 1'b1;
            done          <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q      <= cfg_word[CFG_BITS-2:0];
                        serial_data  <= cfg_word[CFG_BITS-1];
                        serial_clock <= 1'b0;
                        busy         <= 1'b1;
                        cfg_index    <= cfg_index - IDX_ONE;
                        word_q       <= IDX_TOP;
                        bit_q        <= '0;
                        div_q        <= '0;
                        state_q      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_q == DIV_RISE) begin
                        // Midpoint of the bit: data has had CLK_DIV cycles of setup.
                        serial_clock <= 1'b1;
                        div_q        <= div_q + DIV_ONE;
                    end else if (div_q == DIV_LAST) begin
                        // End of the bit: clock falls and the next bit is presented.
                        serial_clock <= 1'b0;
                        div_q        <= '0;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (word_q == '0) begin
                                serial_data <= 1'b0;
                                serial_load <= 1'b1;
                                state_q     <= LOAD;
                            end else begin
                                shreg_q     <= cfg_word[CFG_BITS-2:0];
                                serial_data <= cfg_word[CFG_BITS-1];
                                word_q      <= word_q - IDX_ONE;
                                // Index saturates at pad 0 until the transfer ends.
                                if (cfg_index != '0) begin
                                    cfg_index <= cfg_index - IDX_ONE;
                                end
                            end
                        end else begin
                            bit_q       <= bit_q + BIT_ONE;
                            serial_data <= shreg_q[CFG_BITS-2];
                            shreg_q     <= shreg_q << 1;
                        end
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end

                LOAD: begin
                    if (div_q == DIV_RISE) begin
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cfg_index   <= IDX_TOP;
                        div_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
